fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch front end of the 5-stage pipelined RV32 CPU. It holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register. It also applies hazard-unit stalls and branch flushes from ID. It keeps hardware stall, flush and cycle counters so that the bench and any debug port read the same statistics that are currently tallied in simulation.

Parameters:
ADDR_W, 32, PC / instruction-memory byte-address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  run enable; low = fetch frozen
stall_i  in  1  load-use stall from hazard detection (hold PC and IF/ID)
flush_i  in  1  branch taken, resolved in ID (redirect and squash IF/ID)
branch_target_i  in  ADDR_W  redirect address, valid with flush_i
imem_instr_i  in  INSTR_W  instruction-memory read data (combinational read of imem_addr_o)
imem_addr_o  out  ADDR_W  instruction-memory address
pc_o  out  ADDR_W  current PC
ifid_pc_o  out  ADDR_W  IF/ID: PC of held instruction
ifid_instr_o  out  INSTR_W  IF/ID: held instruction (all-zero when bubble)
ifid_valid_o  out  1  IF/ID: 1 = real instruction, 0 = bubble
stall_cnt_o  out  CNT_W  stall cycles counted
flush_cnt_o  out  CNT_W  flush events counted
cycle_cnt_o  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - pc_o = RESET_PC.
  - ifid_pc_o = 0, ifid_instr_o = 0, ifid_valid_o = 0.
  - All counters = 0.
  - State = IDLE.
- imem_addr_o = pc_o, purely combinational. Zero-latency fetch: instruction at PC is latched into IF/ID on the same edge the PC advances.
- FSM, two states:
  - IDLE: PC, IF/ID and counters hold. Move to RUN on an edge where start_i = 1; that edge already performs a RUN update.
  - RUN: each edge performs one update (below). Move to IDLE on an edge where start_i = 0; that edge performs no update and all state holds.
- RUN update priority: flush_i > stall_i > normal.
  - flush_i = 1:
    - pc <= {branch_target_i[ADDR_W-1:2], 2'b00}; low two bits forced to zero.
    - IF/ID <= bubble (instr 0, valid 0, pc 0).
    - flush_cnt + 1.
    - stall_i is ignored that cycle and stall_cnt is not incremented.
  - stall_i = 1 (no flush): pc holds; IF/ID holds (including valid); stall_cnt + 1.
  - Otherwise: pc <= pc + 4, wrapping modulo 2^ADDR_W; IF/ID <= {pc, imem_instr_i, 1}.
- cycle_cnt + 1 on every RUN edge regardless of the update type.
- All counters saturate at 2^CNT_W - 1 and never wrap.
- An all-zero bubble decodes downstream as no-write / no-memory, so control needs no separate gating of ifid_valid_o (provided for tracing).
- Back-to-back flushes: each edge redirects to the latest target and counts separately.
- Flush while PC = max: the redirect wins, with no wrap artefact.

Decomposition:
- Shared package cpu_pkg:
  - constants ADDR_W, INSTR_W, RESET_PC, NOP_INSTR (= 0), PC_STEP (= 4).
  - enum fetch_state_t {FS_IDLE, FS_RUN}.
- One natural sub-module: sat_counter (CNT_W-wide, increment-enable, saturating, async reset), instantiated three times.
- PC and IF/ID logic stay in fetch_stage.

Test Plan:
- Reset then start_i = 1 for 4 cycles, imem returns 0x00A00093 at every address -> pc_o 0,4,8,12,16; ifid_pc_o trails by one edge; ifid_valid_o = 1 from the first edge; cycle_cnt_o = 4.
- At pc_o = 8, stall_i = 1 for 2 cycles -> pc_o stays 8; IF/ID holds (ifid_pc_o = 4); stall_cnt_o = 2; then resumes 12.
- At pc_o = 12, flush_i = 1 with branch_target_i = 0x1E -> pc_o = 0x1C; IF/ID bubble (instr 0, valid 0); flush_cnt_o = 1.
- stall_i = 1 and flush_i = 1 on the same edge, target 0x40 -> pc_o = 0x40; flush_cnt_o + 1; stall_cnt_o unchanged.
- Drop start_i for 3 cycles mid-run -> pc_o, IF/ID and all counters frozen; start_i = 1 resumes from the frozen PC.
- Assert rst_i between clock edges during RUN -> outputs go to reset values immediately, without waiting for an edge; with CNT_W = 2 and 5 stalls, stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 pipeline front end.
//   ADDR_W / INSTR_W : byte-address and instruction widths
//   RESET_PC         : PC value after reset
//   NOP_INSTR        : all-zero bubble word (decodes as no-write / no-memory)
//   PC_STEP          : sequential PC increment in bytes
//   CNT_W            : default performance-counter width
//   fetch_state_t    : fetch FSM states
package cpu_pkg;

  localparam int                ADDR_W    = 32;
  localparam int                INSTR_W   = 32;
  localparam int                CNT_W     = 32;
  localparam logic [ADDR_W-1:0] RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam int                PC_STEP   = 4;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch-stage performance statistics.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the count
//   inc_i  : increment enable for this edge
//   cnt_o  : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_at_max) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, instruction-memory address,
// IF/ID pipeline register, stall/flush handling and performance counters.
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   start_i               : run enable (low freezes all fetch state)
//   stall_i               : load-use stall, holds PC and IF/ID
//   flush_i               : taken branch from ID, redirects PC and squashes IF/ID
//   branch_target_i       : redirect address, valid with flush_i
//   imem_instr_i          : combinational instruction-memory read data
//   imem_addr_o, pc_o     : instruction address / current PC
//   ifid_pc_o/_instr_o/_valid_o : IF/ID contents (bubble = all zero)
//   stall_cnt_o, flush_cnt_o, cycle_cnt_o : saturating statistics
//
// state   | meaning
// FS_IDLE | fetch frozen, waiting for start_i
// FS_RUN  | one PC/IF-ID update per edge while start_i stays high
module fetch_stage #(
  parameter int                      ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                      INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]       RESET_PC = cpu_pkg::RESET_PC,
  parameter int                      CNT_W    = cpu_pkg::CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);

  import cpu_pkg::*;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic               w_upd;
  logic               w_do_flush;
  logic               w_do_stall;
  logic               w_do_adv;
  logic [ADDR_W-1:0]  w_target;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_ifid_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic               r_ifid_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= FS_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Both states update on an edge with start_i high (IDLE->RUN performs the
  // first update on the same edge); start_i low always freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (start_i) begin
          w_state_nxt = FS_RUN;
          w_upd       = 1'b1;
        end
      end
      FS_RUN: begin
        if (start_i) w_upd       = 1'b1;
        else         w_state_nxt = FS_IDLE;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // Flush outranks stall; a stall coinciding with a flush is dropped.
  assign w_do_flush = w_upd && flush_i;
  assign w_do_stall = w_upd && stall_i && !flush_i;
  assign w_do_adv   = w_upd && !stall_i && !flush_i;

  // Redirect targets are word-aligned by clearing the two low bits.
  assign w_target = branch_target_i & ~ADDR_W'(3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_do_flush) begin
      r_pc         <= w_target;
      r_ifid_pc    <= '0;
      r_ifid_instr <= INSTR_W'(NOP_INSTR);
      r_ifid_valid <= 1'b0;
    end else if (w_do_adv) begin
      r_pc         <= r_pc + ADDR_W'(PC_STEP);
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= imem_instr_i;
      r_ifid_valid <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_do_stall),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_do_flush),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_upd),
    .cnt_o (cycle_cnt_o)
  );

  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_valid_o = r_ifid_valid;

endmodule
